// File: rtl/interrupt_controller_pkg.sv
// Shared types and constants for the 8-line edge-triggered interrupt controller.
package interrupt_controller_pkg;

    localparam int          IC_NUM_IRQ     = 8;
    localparam logic [15:0] IC_VECTOR_BASE = 16'h0010;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } ic_state_e;

endpackage

// File: rtl/interrupt_controller_prio.sv
// Fixed-priority encoder: the lowest set index of the active set wins.
module irq_priority_encoder
    import interrupt_controller_pkg::*;
(
    input  logic [IC_NUM_IRQ-1:0] active_i,
    output logic [2:0]            id_o,
    output logic                  valid_o
);

    // Scan downward so the last assignment is the lowest set index.
    always_comb begin
        id_o = 3'd0;
        for (int i = IC_NUM_IRQ - 1; i >= 0; i--) begin
            if (active_i[i]) begin
                id_o = 3'(i);
            end
        end
    end

    assign valid_o = |active_i;

endmodule

// File: rtl/interrupt_controller.sv
// Edge-triggered, maskable, non-nesting interrupt controller with a vectored bus read-out.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter logic [15:0] VECTOR_BASE = IC_VECTOR_BASE,
    parameter int          NUM_IRQ     = IC_NUM_IRQ
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               mask_write,
    input  logic [15:0]        wr_data,
    input  logic               io_store_retaddr,
    input  logic               io_push_ints,
    input  logic               io_push_int_addr,
    input  logic               eoi,
    output logic               io_interrupt,
    output logic [15:0]        d_out,
    output logic               d_oe,
    output ic_state_e          state_o
);

    ic_state_e          state_q;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] irq_edge, active, clr_mask;
    logic [2:0]         active_id_q, win_id, vec_id;
    logic               win_valid, enter_service, irq_out_q;
    logic [15:0]        vec_addr;
    logic [7:0]         unused_wr_hi;

    assign unused_wr_hi = wr_data[15:8];

    assign irq_edge = irq & ~irq_q;
    assign active   = pending_q & mask_q;

    irq_priority_encoder u_prio (
        .active_i (active),
        .id_o     (win_id),
        .valid_o  (win_valid)
    );

    assign enter_service = (state_q == REQ) && win_valid && io_store_retaddr;
    assign clr_mask      = enter_service ? (NUM_IRQ'(1) << win_id) : '0;

    // A fresh edge on the line being cleared must survive, so the set is OR'd last.
    assign pending_d = (pending_q & ~clr_mask) | irq_edge;
    assign mask_d    = mask_write ? wr_data[NUM_IRQ-1:0] : mask_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q     <= '0;
            pending_q <= '0;
            mask_q    <= '0;
        end else begin
            irq_q     <= irq;
            pending_q <= pending_d;
            mask_q    <= mask_d;
        end
    end

    // io_interrupt is registered alongside the state so it is high exactly in REQ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            active_id_q <= 3'd0;
            irq_out_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_valid) begin
                        state_q   <= REQ;
                        irq_out_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (!win_valid) begin
                        state_q   <= IDLE;
                        irq_out_q <= 1'b0;
                    end else if (io_store_retaddr) begin
                        state_q     <= SERVICE;
                        active_id_q <= win_id;
                        irq_out_q   <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (eoi) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    irq_out_q <= 1'b0;
                end
            endcase
        end
    end

    assign io_interrupt = irq_out_q;
    assign state_o      = state_q;

    assign vec_id   = (state_q == SERVICE) ? active_id_q : win_id;
    assign vec_addr = VECTOR_BASE + {12'b0, vec_id, 1'b0};

    always_comb begin
        d_out = 16'h0000;
        d_oe  = 1'b0;
        if (io_push_int_addr) begin
            d_out = vec_addr;
            d_oe  = 1'b1;
        end else if (io_push_ints) begin
            d_out = {mask_q, pending_q};
            d_oe  = 1'b1;
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: one task per scenario, inline checks, one summary line.
module tb_interrupt_controller;
    import interrupt_controller_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  irq = 8'h00;
    logic        mask_write = 1'b0;
    logic [15:0] wr_data = 16'h0000;
    logic        io_store_retaddr = 1'b0;
    logic        io_push_ints = 1'b0;
    logic        io_push_int_addr = 1'b0;
    logic        eoi = 1'b0;
    logic        io_interrupt;
    logic [15:0] d_out;
    logic        d_oe;
    ic_state_e   state_o;

    int checks = 0;
    int failures = 0;

    interrupt_controller dut (
        .clk              (clk),
        .rst              (rst),
        .irq              (irq),
        .mask_write       (mask_write),
        .wr_data          (wr_data),
        .io_store_retaddr (io_store_retaddr),
        .io_push_ints     (io_push_ints),
        .io_push_int_addr (io_push_int_addr),
        .eoi              (eoi),
        .io_interrupt     (io_interrupt),
        .d_out            (d_out),
        .d_oe             (d_oe),
        .state_o          (state_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mask(input logic [7:0] m);
        wr_data    = {8'h00, m};
        mask_write = 1'b1;
        step();
        mask_write = 1'b0;
        wr_data    = 16'h0000;
    endtask

    task automatic pulse_irq(input logic [7:0] lines);
        irq = lines;
        step();
        irq = 8'h00;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (io_interrupt !== 1'b0 || state_o !== IDLE) begin
            failures++;
            $display("FAIL reset_state: irq_out=%b state=%0d required 0/IDLE", io_interrupt, state_o);
        end
        checks++;
        if (d_oe !== 1'b0 || d_out !== 16'h0000) begin
            failures++;
            $display("FAIL reset_bus_idle: d_oe=%b d_out=%h required 0/0000", d_oe, d_out);
        end
        io_push_ints = 1'b1;
        #1;
        checks++;
        if (d_oe !== 1'b1 || d_out !== 16'h0000) begin
            failures++;
            $display("FAIL reset_status: d_oe=%b d_out=%h required 1/0000", d_oe, d_out);
        end
        io_push_ints = 1'b0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_vector();
        write_mask(8'hFF);
        pulse_irq(8'h08);
        checks++;
        if (io_interrupt !== 1'b0) begin
            failures++;
            $display("FAIL vec_latency_early: irq_out=%b required 0", io_interrupt);
        end
        step();
        checks++;
        if (io_interrupt !== 1'b1 || state_o !== REQ) begin
            failures++;
            $display("FAIL vec_req: irq_out=%b state=%0d required 1/REQ", io_interrupt, state_o);
        end
        io_push_int_addr = 1'b1;
        #1;
        checks++;
        if (d_out !== 16'h0016 || d_oe !== 1'b1) begin
            failures++;
            $display("FAIL vec_addr3: d_out=%h d_oe=%b required 0016/1", d_out, d_oe);
        end
        io_push_int_addr = 1'b0;
        io_store_retaddr = 1'b1;
        step();
        io_store_retaddr = 1'b0;
        io_push_ints = 1'b1;
        #1;
        checks++;
        if (state_o !== SERVICE || io_interrupt !== 1'b0 || d_out !== 16'hFF00) begin
            failures++;
            $display("FAIL vec_ack: state=%0d irq_out=%b d_out=%h required SERVICE/0/FF00", state_o, io_interrupt, d_out);
        end
        io_push_ints = 1'b0;
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        checks++;
        if (state_o !== IDLE) begin
            failures++;
            $display("FAIL vec_eoi: state=%0d required IDLE", state_o);
        end
    endtask

    task automatic test_priority();
        pulse_irq(8'h22);
        step();
        io_push_int_addr = 1'b1;
        #1;
        checks++;
        if (state_o !== REQ || d_out !== 16'h0012) begin
            failures++;
            $display("FAIL prio_winner: state=%0d d_out=%h required REQ/0012", state_o, d_out);
        end
        io_push_int_addr = 1'b0;
        io_store_retaddr = 1'b1;
        step();
        io_store_retaddr = 1'b0;
        io_push_ints = 1'b1;
        #1;
        checks++;
        if (d_out !== 16'hFF20) begin
            failures++;
            $display("FAIL prio_status: d_out=%h required FF20", d_out);
        end
        io_push_ints = 1'b0;
        io_push_int_addr = 1'b1;
        #1;
        checks++;
        if (d_out !== 16'h0012) begin
            failures++;
            $display("FAIL prio_active_id: d_out=%h required 0012", d_out);
        end
        io_push_int_addr = 1'b0;
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        step();
        io_push_int_addr = 1'b1;
        #1;
        checks++;
        if (state_o !== REQ || io_interrupt !== 1'b1 || d_out !== 16'h001A) begin
            failures++;
            $display("FAIL prio_second: state=%0d irq_out=%b d_out=%h required REQ/1/001A", state_o, io_interrupt, d_out);
        end
        io_push_int_addr = 1'b0;
        io_store_retaddr = 1'b1;
        step();
        io_store_retaddr = 1'b0;
        eoi = 1'b1;
        step();
        eoi = 1'b0;
    endtask

    task automatic test_mask_drop();
        pulse_irq(8'h10);
        step();
        write_mask(8'h00);
        checks++;
        if (state_o !== REQ || io_interrupt !== 1'b1) begin
            failures++;
            $display("FAIL mask_still_req: state=%0d irq_out=%b required REQ/1", state_o, io_interrupt);
        end
        step();
        io_push_ints = 1'b1;
        #1;
        checks++;
        if (state_o !== IDLE || io_interrupt !== 1'b0 || d_out !== 16'h0010) begin
            failures++;
            $display("FAIL mask_drop: state=%0d irq_out=%b d_out=%h required IDLE/0/0010", state_o, io_interrupt, d_out);
        end
        io_push_ints = 1'b0;
        io_store_retaddr = 1'b1;
        step();
        io_store_retaddr = 1'b0;
        checks++;
        if (state_o !== IDLE) begin
            failures++;
            $display("FAIL ack_in_idle: state=%0d required IDLE", state_o);
        end
        write_mask(8'hFF);
        step();
        io_store_retaddr = 1'b1;
        step();
        io_store_retaddr = 1'b0;
        eoi = 1'b1;
        step();
        eoi = 1'b0;
    endtask

    task automatic test_nesting();
        pulse_irq(8'h04);
        step();
        io_store_retaddr = 1'b1;
        step();
        io_store_retaddr = 1'b0;
        pulse_irq(8'h01);
        step();
        io_push_int_addr = 1'b1;
        #1;
        checks++;
        if (state_o !== SERVICE || io_interrupt !== 1'b0 || d_out !== 16'h0014) begin
            failures++;
            $display("FAIL nest_hold: state=%0d irq_out=%b d_out=%h required SERVICE/0/0014", state_o, io_interrupt, d_out);
        end
        io_push_int_addr = 1'b0;
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        checks++;
        if (state_o !== IDLE) begin
            failures++;
            $display("FAIL nest_eoi_idle: state=%0d required IDLE", state_o);
        end
        step();
        io_push_int_addr = 1'b1;
        #1;
        checks++;
        if (state_o !== REQ || io_interrupt !== 1'b1 || d_out !== 16'h0010) begin
            failures++;
            $display("FAIL nest_rerequest: state=%0d irq_out=%b d_out=%h required REQ/1/0010", state_o, io_interrupt, d_out);
        end
        io_push_int_addr = 1'b0;
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        checks++;
        if (state_o !== REQ) begin
            failures++;
            $display("FAIL eoi_in_req: state=%0d required REQ", state_o);
        end
        io_store_retaddr = 1'b1;
        step();
        io_store_retaddr = 1'b0;
        eoi = 1'b1;
        step();
        eoi = 1'b0;
    endtask

    task automatic test_set_wins();
        pulse_irq(8'h40);
        step();
        irq = 8'h40;
        io_store_retaddr = 1'b1;
        step();
        io_store_retaddr = 1'b0;
        irq = 8'h00;
        io_push_ints = 1'b1;
        #1;
        checks++;
        if (state_o !== SERVICE || d_out !== 16'hFF40) begin
            failures++;
            $display("FAIL set_wins: state=%0d d_out=%h required SERVICE/FF40", state_o, d_out);
        end
        io_push_ints = 1'b0;
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        step();
        io_store_retaddr = 1'b1;
        step();
        io_store_retaddr = 1'b0;
        eoi = 1'b1;
        step();
        eoi = 1'b0;
    endtask

    task automatic test_push_both();
        pulse_irq(8'h80);
        step();
        io_push_ints = 1'b1;
        io_push_int_addr = 1'b1;
        #1;
        checks++;
        if (d_out !== 16'h001E || d_oe !== 1'b1) begin
            failures++;
            $display("FAIL push_both: d_out=%h d_oe=%b required 001E/1", d_out, d_oe);
        end
        io_push_ints = 1'b0;
        io_push_int_addr = 1'b0;
        #1;
        checks++;
        if (d_out !== 16'h0000 || d_oe !== 1'b0) begin
            failures++;
            $display("FAIL push_none: d_out=%h d_oe=%b required 0000/0", d_out, d_oe);
        end
        io_store_retaddr = 1'b1;
        step();
        io_store_retaddr = 1'b0;
    endtask

    task automatic test_reset_service();
        pulse_irq(8'h20);
        checks++;
        if (state_o !== SERVICE) begin
            failures++;
            $display("FAIL rst_pre_service: state=%0d required SERVICE", state_o);
        end
        irq = 8'h04;
        #2;
        rst = 1'b1;
        #1;
        io_push_ints = 1'b1;
        #1;
        checks++;
        if (state_o !== IDLE || io_interrupt !== 1'b0 || d_out !== 16'h0000) begin
            failures++;
            $display("FAIL rst_async: state=%0d irq_out=%b d_out=%h required IDLE/0/0000", state_o, io_interrupt, d_out);
        end
        io_push_ints = 1'b0;
        step();
        rst = 1'b0;
        step();
        io_push_ints = 1'b1;
        #1;
        checks++;
        if (d_out !== 16'h0004 || state_o !== IDLE) begin
            failures++;
            $display("FAIL rst_level_edge: d_out=%h state=%0d required 0004/IDLE", d_out, state_o);
        end
        io_push_ints = 1'b0;
        irq = 8'h00;
        write_mask(8'hFF);
        step();
        checks++;
        if (state_o !== REQ || io_interrupt !== 1'b1) begin
            failures++;
            $display("FAIL rst_no_eoi: state=%0d irq_out=%b required REQ/1", state_o, io_interrupt);
        end
    endtask

    initial begin
        test_reset();
        test_vector();
        test_priority();
        test_mask_drop();
        test_nesting();
        test_set_wins();
        test_push_both();
        test_reset_service();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
